// File: rtl/imem_loader.sv
// Boot-time instruction memory loader. Streams DATA_W-bit words into the
// core's instruction memory, checks a running modulo-2**DATA_W sum against an
// expected value, and keeps the core in reset until the program is in place.
module imem_loader #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int HOLD_CYC = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [DATA_W-1:0] exp_sum,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              core_reset_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int                HOLD_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
  localparam logic [ADDR_W:0]   MAX_CNT   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ADDR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HOLD,
    ST_RUN,
    ST_FAIL
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W:0]     r_count;
  logic [ADDR_W:0]     r_addr;
  logic [DATA_W-1:0]   r_exp;
  logic [DATA_W-1:0]   r_sum;
  logic [HOLD_W-1:0]   r_hold;
  logic                r_we;
  logic [ADDR_W-1:0]   r_waddr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_err;

  logic                w_can_start;
  logic                w_cnt_ok;
  logic                w_start_ok;
  logic                w_start_bad;
  logic                w_xfer;
  logic                w_last;
  logic                w_hold_end;
  logic                w_sum_ok;

  // Decode handshakes, start acceptance and the next state.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_state_nxt = r_state;
    w_can_start = (r_state == ST_IDLE) || (r_state == ST_RUN) || (r_state == ST_FAIL);
    w_cnt_ok    = (word_count != '0) && (word_count <= MAX_CNT);
    w_start_ok  = w_can_start && start && w_cnt_ok;
    w_start_bad = w_can_start && start && !w_cnt_ok;
    w_xfer      = (r_state == ST_LOAD) && s_valid;
    w_last      = w_xfer && ((r_addr + ADDR_ONE) == r_count);
    w_hold_end  = (r_state == ST_HOLD) && (r_hold == HOLD_LAST);
    w_sum_ok    = (r_sum == r_exp);

    unique case (r_state)
      ST_IDLE, ST_RUN, ST_FAIL: begin
        if (w_start_ok)       w_state_nxt = ST_LOAD;
        else if (w_start_bad) w_state_nxt = ST_FAIL;
      end
      ST_LOAD: if (w_last) w_state_nxt = ST_HOLD;
      ST_HOLD: if (w_hold_end) w_state_nxt = w_sum_ok ? ST_RUN : ST_FAIL;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!RESET_N) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Load datapath: latched parameters, address/sum counters, registered write.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_count <= '0;
      r_exp   <= '0;
      r_addr  <= '0;
      r_sum   <= '0;
      r_hold  <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_we <= w_xfer;
      if (w_xfer) begin
        r_waddr <= r_addr[ADDR_W-1:0];
        r_wdata <= s_data;
        r_sum   <= r_sum + s_data;
        r_addr  <= r_addr + ADDR_ONE;
      end

      if (r_state == ST_HOLD) r_hold <= r_hold + 1'b1;
      else                    r_hold <= '0;

      if (w_start_ok) begin
        r_count <= word_count;
        r_exp   <= exp_sum;
        r_addr  <= '0;
        r_sum   <= '0;
        r_err   <= 1'b0;
      end else if (w_start_bad || (w_hold_end && !w_sum_ok)) begin
        r_err   <= 1'b1;
      end
    end
  end

  assign s_ready      = (r_state == ST_LOAD);
  assign busy         = (r_state == ST_LOAD) || (r_state == ST_HOLD);
  assign done         = (r_state == ST_RUN);
  assign core_reset_n = (r_state == ST_RUN);
  assign err          = r_err;
  assign imem_we      = r_we;
  assign imem_addr    = r_waddr;
  assign imem_wdata   = r_wdata;

endmodule

// File: tb/tb_imem_loader.sv
// Directed/random bench for imem_loader: drives program loads and compares
// writes, handshakes and status outputs against a simple program-level model.
module tb_imem_loader;

  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 32;
  localparam int HOLD_CYC = 4;

  logic              CLK = 1'b0;
  logic              RESET_N = 1'b1;
  logic              start;
  logic [ADDR_W:0]   word_count;
  logic [DATA_W-1:0] exp_sum;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              core_reset_n;
  logic              busy;
  logic              done;
  logic              err;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  int                n_assert = 0;
  int                n_fail   = 0;
  int                spurious = 0;
  logic              prev_hs;
  logic [DATA_W-1:0] words[$];
  wr_t               wq[$];

  imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HOLD_CYC(HOLD_CYC)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .start(start), .word_count(word_count),
    .exp_sum(exp_sum), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_reset_n(core_reset_n), .busy(busy), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  // Write monitor: records every memory write and counts any write that does
  // not follow a handshake on the previous edge (or a handshake with no write).
  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      prev_hs <= 1'b0;
    end else begin
      if (imem_we !== prev_hs) spurious <= spurious + 1;
      if (imem_we === 1'b1) wq.push_back('{imem_addr, imem_wdata});
      prev_hs <= s_valid && s_ready;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"},      s_ready,      0);
    check({tag, "_imem_we"},      imem_we,      0);
    check({tag, "_imem_addr"},    imem_addr,    0);
    check({tag, "_imem_wdata"},   imem_wdata,   0);
    check({tag, "_core_reset_n"}, core_reset_n, 0);
    check({tag, "_busy"},         busy,         0);
    check({tag, "_done"},         done,         0);
    check({tag, "_err"},          err,          0);
  endtask

  // One program load. mode: 0 continuous valid, 1 valid pattern 1,0,0, 2 random.
  // delta is added to the correct checksum; abort_after >= 0 pulls reset after
  // that many accepted words.
  task automatic do_load(input int n, input logic [DATA_W-1:0] delta, input int mode,
                         input bit poke_start, input int abort_after, input string tag);
    logic [DATA_W-1:0] sum;
    int base, sp0, idx, cyc, bad;
    bit hs, ok;
    sum = '0;
    for (int i = 0; i < n; i++) sum += words[i];
    ok   = (delta == '0);
    base = wq.size();
    sp0  = spurious;

    start = 1'b1; word_count = (ADDR_W+1)'(n); exp_sum = sum + delta;
    @(posedge CLK); #1;
    start = 1'b0;
    check({tag, "_enter_busy"},   busy,         1);
    check({tag, "_enter_ready"},  s_ready,      1);
    check({tag, "_enter_corern"}, core_reset_n, 0);
    check({tag, "_enter_done"},   done,         0);
    check({tag, "_enter_err"},    err,          0);

    idx = 0; cyc = 0;
    while (idx < n && cyc < 4 * n + 100) begin
      case (mode)
        0:       s_valid = 1'b1;
        1:       s_valid = (cyc % 3 == 0);
        default: s_valid = 1'($urandom_range(0, 1));
      endcase
      s_data = s_valid ? words[idx] : $urandom;
      if (poke_start && cyc == 2) begin
        start = 1'b1; word_count = 1; exp_sum = '0;
      end else begin
        start = 1'b0;
      end
      hs = s_valid && s_ready;
      @(posedge CLK);
      if (hs) idx++;
      #1;
      cyc++;
      if (abort_after >= 0 && idx == abort_after) begin
        RESET_N = 1'b0; s_valid = 1'b0; start = 1'b0;
        #1;
        check_reset_outputs({tag, "_async_rst"});
        check({tag, "_rst_nwrites"}, wq.size() - base, abort_after - 1);
        repeat (2) @(posedge CLK);
        #1 RESET_N = 1'b1;
        @(posedge CLK); #1;
        check_reset_outputs({tag, "_after_rst"});
        return;
      end
    end
    s_valid = 1'b0; start = 1'b0;
    check({tag, "_accepted"}, idx, n);

    // First HOLD cycle: stream closed, final write on the bus.
    check({tag, "_hold_ready"}, s_ready,    0);
    check({tag, "_hold_busy"},  busy,       1);
    check({tag, "_last_we"},    imem_we,    1);
    check({tag, "_last_addr"},  imem_addr,  n - 1);
    check({tag, "_last_data"},  imem_wdata, words[n-1]);
    repeat (HOLD_CYC - 1) begin
      @(posedge CLK); #1;
      check({tag, "_hold_corern"}, core_reset_n, 0);
      check({tag, "_hold_busy2"},  busy,         1);
    end
    @(posedge CLK); #1;
    check({tag, "_end_done"},   done,         ok);
    check({tag, "_end_corern"}, core_reset_n, ok);
    check({tag, "_end_err"},    err,          !ok);
    check({tag, "_end_busy"},   busy,         0);
    repeat (2) @(posedge CLK);
    #1;
    check({tag, "_stay_corern"}, core_reset_n, ok);

    check({tag, "_nwrites"}, wq.size() - base, n);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (base + i < wq.size()) begin
        if (wq[base+i].a !== ADDR_W'(i) || wq[base+i].d !== words[i]) bad++;
      end
    end
    check({tag, "_write_content"}, bad, 0);
    check({tag, "_unpaired_we"}, spurious - sp0, 0);
  endtask

  task automatic bad_start(input int cnt, input string tag);
    int base, sp0;
    base = wq.size(); sp0 = spurious;
    start = 1'b1; word_count = (ADDR_W+1)'(cnt); exp_sum = '0;
    s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
    @(posedge CLK); #1;
    start = 1'b0;
    check({tag, "_err"},    err,          1);
    check({tag, "_busy"},   busy,         0);
    check({tag, "_ready"},  s_ready,      0);
    check({tag, "_done"},   done,         0);
    check({tag, "_corern"}, core_reset_n, 0);
    repeat (3) @(posedge CLK);
    #1 s_valid = 1'b0;
    check({tag, "_nowrite"}, wq.size() - base, 0);
    check({tag, "_unpaired_we"}, spurious - sp0, 0);
  endtask

  initial begin
    start = 1'b0; word_count = '0; exp_sum = '0; s_valid = 1'b0; s_data = '0;
    #2 RESET_N = 1'b0;
    #1 check_reset_outputs("por");
    repeat (2) @(posedge CLK);
    #1 RESET_N = 1'b1;
    @(posedge CLK); #1;
    check_reset_outputs("idle");

    words = '{32'h00500093, 32'h00100113, 32'h002081B3, 32'h00000013, 32'h0000006F};
    do_load(5, 32'd0, 0, 1'b0, -1, "fibo");
    do_load(5, 32'd0, 1, 1'b0, -1, "fibo_toggle");
    do_load(5, 32'd1, 0, 1'b0, -1, "fibo_badsum");

    bad_start(0, "cnt0");
    bad_start(1025, "cnt1025");
    do_load(5, 32'd0, 2, 1'b0, -1, "recover");

    words.delete();
    for (int i = 0; i < 32; i++) words.push_back($urandom);
    do_load(32, 32'd0, 2, 1'b1, -1, "bubble");

    words.delete();
    for (int i = 0; i < 8; i++) words.push_back($urandom);
    do_load(8, 32'd0, 0, 1'b0, 3, "abort");
    do_load(8, 32'd0, 1, 1'b0, -1, "reload");

    words.delete();
    for (int i = 0; i < (1 << ADDR_W); i++) words.push_back($urandom);
    do_load(1 << ADDR_W, 32'd0, 2, 1'b0, -1, "full");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
